// File: rtl/sip_operand_feeder.sv
// Packs narrow act/weight beats into N_DOT-lane vectors for the SIP dot unit.
// Optional zero-padding of short vectors via i_Last when SIP_FEED_ZPAD_EN is defined.
module sip_operand_feeder #(
  parameter int unsigned N_DOT         = 32,
  parameter int unsigned BITS_PARALLEL = 2,
  parameter int unsigned IN_LANES      = 4
) (
  input  logic                              i_Clk,
  input  logic                              i_Rst_n,
  input  logic                              i_Valid,
  output logic                              o_Ready,
  input  logic [IN_LANES*BITS_PARALLEL-1:0] i_Act,
  input  logic [IN_LANES*BITS_PARALLEL-1:0] i_Weight,
  input  logic                              i_SignI,
  input  logic                              i_SignW,
  input  logic                              i_Last,
  output logic                              o_Valid,
  input  logic                              i_Ready,
  output logic [N_DOT*BITS_PARALLEL-1:0]    o_Act,
  output logic [N_DOT*BITS_PARALLEL-1:0]    o_Weight,
  output logic                              o_SignI,
  output logic                              o_SignW,
  output logic [N_DOT-1:0]                  o_PadMask
);

  localparam int unsigned BEATS = N_DOT / IN_LANES;
  localparam int unsigned IN_W  = IN_LANES * BITS_PARALLEL;
  localparam int unsigned VEC_W = N_DOT * BITS_PARALLEL;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_FULL = 1'b1;

  logic [0:0]       state, state_n;
  logic [CNT_W-1:0] beat_cnt, cnt_n;
  logic [VEC_W-1:0] fill_act, fill_act_n;
  logic [VEC_W-1:0] fill_wt, fill_wt_n;
  logic             fill_si, fill_si_n;
  logic             fill_sw, fill_sw_n;
  logic [N_DOT-1:0] fill_pad, fill_pad_n;
  logic             accept;
  logic             end_vec;
  logic             load;
  logic             unused_last;

  assign unused_last = i_Last;
  // o_Ready is registered and only ever high in FILL, so it gates acceptance.
  assign accept = i_Valid & o_Ready;

  // Next-state, fill-register update and output-load decision.
  always_comb begin
    state_n    = state;
    cnt_n      = beat_cnt;
    fill_act_n = fill_act;
    fill_wt_n  = fill_wt;
    fill_si_n  = fill_si;
    fill_sw_n  = fill_sw;
    fill_pad_n = fill_pad;
    end_vec    = 1'b0;
    load       = 1'b0;
    case (state)
      S_FILL: begin
        if (accept) begin
          // First beat starts a clean vector so no stale lanes survive.
          if (beat_cnt == '0) begin
            fill_act_n = '0;
            fill_wt_n  = '0;
            fill_si_n  = i_SignI;
            fill_sw_n  = i_SignW;
          end
          fill_pad_n = '0;
          for (int unsigned b = 0; b < BEATS; b++) begin
            if (beat_cnt == CNT_W'(b)) begin
              fill_act_n[b*IN_W +: IN_W] = i_Act;
              fill_wt_n[b*IN_W +: IN_W]  = i_Weight;
            end
          end
          end_vec = (beat_cnt == CNT_W'(BEATS - 1));
`ifdef SIP_FEED_ZPAD_EN
          if (i_Last && !end_vec) begin
            for (int unsigned b = 0; b < BEATS; b++) begin
              if (beat_cnt == CNT_W'(b)) begin
                for (int unsigned l = 0; l < N_DOT; l++) begin
                  if (l >= (b + 1) * IN_LANES) fill_pad_n[l] = 1'b1;
                end
              end
            end
          end
          end_vec = end_vec | i_Last;
`endif
          if (end_vec) begin
            state_n = S_FULL;
            cnt_n   = '0;
          end else begin
            cnt_n = beat_cnt + CNT_W'(1);
          end
        end
      end
      S_FULL: begin
        if (!o_Valid || i_Ready) begin
          load    = 1'b1;
          state_n = S_FILL;
        end
      end
      default: state_n = S_FILL;
    endcase
  end

  // FSM state, beat counter, fill register and ready flag.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state    <= S_FILL;
      beat_cnt <= '0;
      fill_act <= '0;
      fill_wt  <= '0;
      fill_si  <= 1'b0;
      fill_sw  <= 1'b0;
      fill_pad <= '0;
      o_Ready  <= 1'b0;
    end else begin
      state    <= state_n;
      beat_cnt <= cnt_n;
      fill_act <= fill_act_n;
      fill_wt  <= fill_wt_n;
      fill_si  <= fill_si_n;
      fill_sw  <= fill_sw_n;
      fill_pad <= fill_pad_n;
      o_Ready  <= (state_n == S_FILL);
    end
  end

  // Output register: data holds unless a new vector loads.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Valid   <= 1'b0;
      o_Act     <= '0;
      o_Weight  <= '0;
      o_SignI   <= 1'b0;
      o_SignW   <= 1'b0;
      o_PadMask <= '0;
    end else if (load) begin
      o_Valid   <= 1'b1;
      o_Act     <= fill_act;
      o_Weight  <= fill_wt;
      o_SignI   <= fill_si;
      o_SignW   <= fill_sw;
      o_PadMask <= fill_pad;
    end else if (i_Ready) begin
      o_Valid <= 1'b0;
    end
  end

endmodule
